// File: rtl/sc_arith_unit.sv
// ---------------------------------------------------------------------------
// sc_arith_unit
//
// Stochastic-computing arithmetic core. Two WIDTH-bit operands are shifted in
// serially (LSB first), each is turned into a stochastic bitstream by
// comparing it against pseudo-random slices of a 31-bit LFSR, and the two
// streams are combined in one of four modes. The ones in the combined stream
// are counted over a 2^LOG_WIN cycle window. The top WIDTH+1 bits of that
// count are returned with a one-cycle valid pulse.
//
// Compile-time option:
//   SC_DUAL_LFSR_EN  defined    : a second LFSR (seed 31'h05A5A5A5) drives the
//                                 B comparator and the MUX select, so the A
//                                 and B streams are decorrelated.
//                    undefined  : one LFSR; B uses its top WIDTH bits and the
//                                 select uses bit 15.
//
// Parameters:
//   WIDTH      operand width (4..15)
//   LOG_WIN    log2 of the counting window (WIDTH..20)
//   LFSR_SEED  nonzero reset value of the primary LFSR
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset; aborts any operation
//   start         request, accepted only while idle
//   mode          00 bipolar mul (XNOR), 01 scaled add (MUX),
//                 10 unipolar mul (AND), 11 unipolar saturating add (OR)
//   ser_a, ser_b  serial operand data, LSB first, sampled during LOAD
//   busy          high in LOAD, RUN and DONE
//   result        window count >> (LOG_WIN-WIDTH); held between results
//   result_valid  one-cycle pulse, coincident with the DONE state
// ---------------------------------------------------------------------------
module sc_arith_unit #(
    parameter int          WIDTH     = 9,
    parameter int          LOG_WIN   = 17,
    parameter logic [30:0] LFSR_SEED = 31'd134995
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             ser_a,
    input  logic             ser_b,
    output logic             busy,
    output logic [WIDTH:0]   result,
    output logic             result_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One shared cycle counter serves both LOAD (WIDTH cycles) and RUN
    // (2^LOG_WIN cycles); LOG_WIN >= WIDTH so it is always wide enough.
    localparam logic [LOG_WIN-1:0] LOAD_LAST = LOG_WIN'(WIDTH - 1);

    state_t               state_reg, state_next;
    logic [1:0]           mode_reg;
    logic [WIDTH-1:0]     op_a_reg, op_b_reg;
    logic [LOG_WIN-1:0]   cnt_reg;
    logic [LOG_WIN:0]     ones_reg, ones_next;
    logic [WIDTH:0]       result_reg;
    logic [30:0]          lfsr_reg, lfsr_next;

    logic                 load_last, run_last;
    logic [WIDTH-1:0]     rand_a, rand_b;
    logic                 rand_sel;
    logic                 sn_a, sn_b, sn_bit;

    // ---------------------------------------------------------------------
    // Random sources
    // ---------------------------------------------------------------------
    assign lfsr_next = {lfsr_reg[29:0], lfsr_reg[27] ^ lfsr_reg[30]};

`ifdef SC_DUAL_LFSR_EN
    logic [30:0] lfsr2_reg, lfsr2_next;

    assign lfsr2_next = {lfsr2_reg[29:0], lfsr2_reg[27] ^ lfsr2_reg[30]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr2_reg <= 31'h05A5A5A5;
        end else begin
            lfsr2_reg <= lfsr2_next;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rand_slices
            assign rand_a[gi] = lfsr_reg[gi];
            assign rand_b[gi] = lfsr2_reg[gi];
        end
    endgenerate

    assign rand_sel = lfsr2_reg[30];
`else
    // B takes the top WIDTH bits, which never overlap A's low slice because
    // WIDTH <= 15.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rand_slices
            assign rand_a[gi] = lfsr_reg[gi];
            assign rand_b[gi] = lfsr_reg[31 - WIDTH + gi];
        end
    endgenerate

    assign rand_sel = lfsr_reg[15];
`endif

    // ---------------------------------------------------------------------
    // Stochastic number generation and combination
    // ---------------------------------------------------------------------
    assign sn_a = (rand_a < op_a_reg);
    assign sn_b = (rand_b < op_b_reg);

    always_comb begin
        sn_bit = 1'b0;
        case (mode_reg)
            2'b00:   sn_bit = ~(sn_a ^ sn_b);
            2'b01:   sn_bit = rand_sel ? sn_b : sn_a;
            2'b10:   sn_bit = sn_a & sn_b;
            default: sn_bit = sn_a | sn_b;
        endcase
    end

    // The count is one bit wider than the window, so a window of all ones
    // lands exactly on 2^LOG_WIN without wrapping.
    assign ones_next = ones_reg + {{LOG_WIN{1'b0}}, sn_bit};

    assign load_last = (cnt_reg == LOAD_LAST);
    assign run_last  = &cnt_reg;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)     state_next = ST_LOAD;
            ST_LOAD: if (load_last) state_next = ST_RUN;
            ST_RUN:  if (run_last)  state_next = ST_DONE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        busy         = (state_reg != ST_IDLE);
        result_valid = (state_reg == ST_DONE);
    end

    assign result = result_reg;

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_reg   <= LFSR_SEED;
            mode_reg   <= 2'b00;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            cnt_reg    <= '0;
            ones_reg   <= '0;
            result_reg <= '0;
        end else begin
            // The LFSR free-runs in every state so successive runs see
            // different random sequences.
            lfsr_reg <= lfsr_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mode_reg <= mode;
                        op_a_reg <= '0;
                        op_b_reg <= '0;
                        cnt_reg  <= '0;
                        ones_reg <= '0;
                    end
                end
                ST_LOAD: begin
                    // Shift in at the MSB: after WIDTH cycles the first bit
                    // received has reached bit 0.
                    op_a_reg <= {ser_a, op_a_reg[WIDTH-1:1]};
                    op_b_reg <= {ser_b, op_b_reg[WIDTH-1:1]};
                    cnt_reg  <= load_last ? '0 : cnt_reg + 1'b1;
                end
                ST_RUN: begin
                    ones_reg <= ones_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    // Capture on the final window cycle, using the count that
                    // already includes that cycle's bit, so result is stable
                    // throughout DONE alongside result_valid.
                    if (run_last) begin
                        result_reg <= ones_next[LOG_WIN -: WIDTH+1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_arith_unit.sv
// ---------------------------------------------------------------------------
// tb_sc_arith_unit
//
// Randomised and directed bench for sc_arith_unit (WIDTH=9, LOG_WIN=10).
// The driver issues operations and pushes each expected response (value,
// cycle it must appear in, and an optional tolerance band) into a queue; a
// separate monitor pops and compares whenever result_valid is seen.
// The reference model regenerates the random sequence from the LFSR rule and
// counts ones over the window with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_sc_arith_unit;

    localparam int          W     = 9;
    localparam int          LW    = 10;
    localparam int          NRUN  = 1 << LW;
    localparam logic [30:0] SEED  = 31'd134995;
    localparam logic [30:0] SEED2 = 31'h05A5A5A5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         ser_a = 1'b0;
    logic         ser_b = 1'b0;
    logic         busy;
    logic [W:0]   result;
    logic         result_valid;

    sc_arith_unit #(
        .WIDTH     (W),
        .LOG_WIN   (LW),
        .LFSR_SEED (SEED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .ser_a        (ser_a),
        .ser_b        (ser_b),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges so far; stable at each falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference random sources, following the documented LFSR rule.
    function automatic logic [30:0] step(input logic [30:0] l);
        return {l[29:0], l[27] ^ l[30]};
    endfunction

    logic [30:0] m_l, m_l2;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_l  <= SEED;
            m_l2 <= SEED2;
        end else begin
            m_l  <= step(m_l);
            m_l2 <= step(m_l2);
        end
    end

    // Expected result: LFSR values l/l2 are those of the accepting cycle;
    // the window covers the NRUN cycles that follow the W load cycles.
    function automatic int predict(input logic [30:0] l0, input logic [30:0] l20,
                                   input logic [1:0] md, input int a, input int b);
        logic [30:0] l, l2;
        int ra, rb, ones;
        bit rs, sa, sb, bt;
        l = l0;
        l2 = l20;
        ones = 0;
        for (int i = 1; i <= W + NRUN; i++) begin
            l  = step(l);
            l2 = step(l2);
            if (i > W) begin
                ra = int'(l) % (1 << W);
`ifdef SC_DUAL_LFSR_EN
                rb = int'(l2) % (1 << W);
                rs = l2[30];
`else
                rb = int'(l) >> (31 - W);
                rs = l[15];
`endif
                sa = (ra < a);
                sb = (rb < b);
                case (md)
                    2'd0:    bt = (sa == sb);
                    2'd1:    bt = rs ? sb : sa;
                    2'd2:    bt = sa && sb;
                    default: bt = sa || sb;
                endcase
                ones += int'(bt);
            end
        end
        return ones >> (LW - W);
    endfunction

    typedef struct {
        int          due;
        logic [W:0]  exp;
        int          lo;
        int          hi;
        string       tag;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (result_valid) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_valid cyc=%0d result=%0d required=no valid", cyc, result);
                    end else begin
                        e = q.pop_front();
                        $display("run %s: result=%0d expected=%0d cyc=%0d due=%0d", e.tag, result, e.exp, cyc, e.due);
                        total++;
                        if (result !== e.exp) begin
                            bad++;
                            $display("FAIL result_%s got=%0d required=%0d", e.tag, result, e.exp);
                        end
                        total++;
                        if (cyc != e.due) begin
                            bad++;
                            $display("FAIL latency_%s got_cycle=%0d required_cycle=%0d", e.tag, cyc, e.due);
                        end
                        if (e.lo >= 0) begin
                            total++;
                            if (int'(result) < e.lo || int'(result) > e.hi) begin
                                bad++;
                                $display("FAIL range_%s got=%0d required=%0d..%0d", e.tag, result, e.lo, e.hi);
                            end
                        end
                    end
                end else if (q.size() > 0 && cyc > q[0].due) begin
                    e = q.pop_front();
                    total++; bad++;
                    $display("FAIL missing_valid_%s cyc=%0d required_cycle=%0d", e.tag, cyc, e.due);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver
    // ---------------------------------------------------------------------
    task automatic check_bit(input string name, input logic got, input logic req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0b required=%0b", name, got, req);
        end
    endtask

    // Called at the falling edge of an idle cycle; returns at the falling
    // edge of the idle cycle following DONE. While busy, start and mode are
    // scrambled (or start held high) to show they are ignored.
    task automatic run_op(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, input int lo, input int hi, input string tag);
        exp_t e;
        check_bit({"busy_idle_", tag}, busy, 1'b0);
        start = 1'b1;
        mode  = md;
        ser_a = 1'($urandom);
        ser_b = 1'($urandom);
        e.due = cyc + W + NRUN + 1;
        e.exp = (W+1)'(predict(m_l, m_l2, md, int'(a), int'(b)));
        e.lo  = lo;
        e.hi  = hi;
        e.tag = tag;
        q.push_back(e);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (k == 1) check_bit({"busy_load_", tag}, busy, 1'b1);
            start = hold ? 1'b1 : 1'($urandom);
            mode  = 2'($urandom);
            ser_a = a[k-1];
            ser_b = b[k-1];
        end
        for (int k = 0; k < NRUN + 2; k++) begin
            @(negedge clk);
            start = hold ? 1'b1 : 1'($urandom);
            mode  = 2'($urandom);
            ser_a = 1'($urandom);
            ser_b = 1'($urandom);
        end
        start = hold;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_valid", result_valid, 1'b0);
        total++;
        if (result !== '0) begin
            bad++;
            $display("FAIL reset_result got=%0d required=0", result);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 9'd0, 9'd0, 1'b0, 512, 512, "xnor_zero");

        // Abort mid-RUN with a 3-cycle reset; nothing may be reported.
        start = 1'b1;
        mode  = 2'b00;
        repeat (W + 100) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_valid", result_valid, 1'b0);
        total++;
        if (result !== '0) begin
            bad++;
            $display("FAIL abort_result got=%0d required=0", result);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b10, 9'd0, 9'd511, 1'b0, 0, 0, "and_zero");
        run_op(2'b11, 9'd0, 9'd0, 1'b0, 0, 0, "or_zero");
        run_op(2'b10, 9'd256, 9'd256, 1'b0, 112, 144, "and_half");
        run_op(2'b01, 9'd0, 9'd511, 1'b0, 232, 280, "mux_add");

        // Three back-to-back runs with start held high throughout.
        for (int r = 0; r < 3; r++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(2'($urandom), ra, rb, (r < 2), -1, -1, $sformatf("b2b%0d", r));
        end

        run_op(2'b10, 9'd1, 9'd511, 1'b0, 0, 2, "serial_order");

        for (int r = 0; r < 5; r++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(2'($urandom), ra, rb, 1'b0, -1, -1, $sformatf("rand%0d", r));
        end

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain outstanding=%0d required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
